arranque_rampa_multinivel: RTL and testbench
============================================

ARRANQUE_RAMPA_MULTINIVEL -- requirements
Module: arranque_rampa_multinivel

Interface
REQ-001 Parameter N_LEVELS, default 3: number of non-zero speed levels, SHALL be >= 2.
REQ-002 Parameter TICK_DIV, default 100000: clk cycles per ramp tick, SHALL be >= 1.
REQ-003 Parameter FAST_DWELL, default 2: ticks spent per level in fast mode, SHALL be >= 1.
REQ-004 Parameter SLOW_DWELL, default 8: ticks spent per level in slow mode, SHALL be >= 1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rapido  in  1  run request, fast ramp.
REQ-008 lento  in  1  run request, slow ramp.
REQ-009 fault  in  1  emergency off, level-sensitive.
REQ-010 level  out  LVL_W = clog2(N_LEVELS+1)  current speed level, 0 = off, N_LEVELS = full.
REQ-011 out_lvl  out  N_LEVELS  one-hot of level: bit i high iff level == i+1; all zero when level = 0.
REQ-012 busy  out  1  high in RAMP_UP or RAMP_DOWN.
REQ-013 at_speed  out  1  high iff state = RUN.

Function
REQ-014 The block SHALL generate a one-cycle tick every TICK_DIV cycles from a free-running counter cleared only by reset; with TICK_DIV = 1, tick SHALL be high every cycle.
REQ-015 The block SHALL define req = rapido | lento, with mode FAST when rapido = 1 (rapido wins when both are high) and SLOW otherwise.
REQ-016 The FSM SHALL have the states IDLE, RAMP_UP, RUN and RAMP_DOWN.
REQ-017 In IDLE with req = 1 and fault = 0, the next edge SHALL latch mode, set level to 1, clear dwell_cnt and enter RAMP_UP, independent of tick.
REQ-018 In RAMP_UP, on each tick dwell_cnt SHALL increment; on a tick with dwell_cnt = DWELL-1 (DWELL taken from the latched mode), level SHALL increment and dwell_cnt SHALL clear.
REQ-019 When RAMP_UP reaches level = N_LEVELS, the same edge SHALL enter RUN.
REQ-020 Mode changes while in RAMP_UP or RUN SHALL be ignored; the latched mode SHALL hold until the state returns to RAMP_UP from RAMP_DOWN or from IDLE.
REQ-021 With req = 0 in RAMP_UP or RUN, the next edge SHALL enter RAMP_DOWN, clear dwell_cnt and keep level unchanged.
REQ-022 In RAMP_DOWN, level SHALL decrement using the rule of REQ-018; reaching level 0 SHALL enter IDLE on the same edge.
REQ-023 With req = 1 in RAMP_DOWN, the next edge SHALL re-latch mode, clear dwell_cnt and enter RAMP_UP at the current level (no decrement on that edge).
REQ-024 fault = 1 in any state SHALL force level 0, IDLE and dwell_cnt 0 on the next edge; it overrides req, and IDLE SHALL not be left while fault = 1.
REQ-025 level SHALL never exceed N_LEVELS nor underflow below 0.
REQ-026 All outputs SHALL be registered or decoded only from registered state, with no combinational path from inputs to outputs.

Reset
REQ-027 reset SHALL put the block in IDLE with level = 0, out_lvl = 0, busy = 0, at_speed = 0, dwell_cnt = 0, prescaler = 0 and mode = SLOW.
REQ-028 reset SHALL take priority over fault and req, including mid-ramp.

Structure
REQ-029 The state enum, the mode enum and the LVL_W computation SHALL live in the shared package arranque_pkg.
REQ-030 The tick generator SHALL be a sub-module named prescaler_tick with parameter DIV, ports clk, reset and tick.
REQ-031 Illegal parameter values SHALL be caught by an elaboration-time check.

Verification
Benches SHALL use TICK_DIV = 1, N_LEVELS = 3, FAST_DWELL = 2 and SLOW_DWELL = 4.
REQ-032 Fast ramp: rapido rises before edge 1 -> level 1 after edge 1, 2 after edge 3, 3 after edge 5, with at_speed = 1 and busy = 0 from edge 5.
REQ-033 Slow ramp and priority: lento alone -> level steps every 4 cycles; rapido and lento together -> FAST timing as in REQ-032.
REQ-034 Ramp-down: drop req in RUN -> RAMP_DOWN after 1 edge, level 3 -> 2 -> 1 -> 0 every DWELL cycles, then IDLE with out_lvl = 000.
REQ-035 Reversal: reassert rapido in RAMP_DOWN at level 2 -> RAMP_UP at level 2, level 3 two edges later, mode FAST.
REQ-036 Fault and reset: fault pulse at level 2 mid-ramp -> level 0 and IDLE on the next edge, ignoring req; reset asserted together with fault and req -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/arranque_pkg.sv
// arranque_pkg: shared FSM/mode types and level-width helper for the multilevel ramp starter
// Contents: state_t (IDLE, RAMP_UP, RUN, RAMP_DOWN), mode_t (SLOW, FAST),
//           lvl_w(n) = bits needed to hold speed levels 0..n
package arranque_pkg;
    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;
    typedef enum logic {SLOW, FAST} mode_t;
    function automatic int lvl_w(input int n_levels);
        return $clog2(n_levels + 1);
    endfunction
endpackage

// File: rtl/prescaler_tick.sv
// prescaler_tick: free-running divider producing a one-cycle tick every DIV clocks
// Ports: clk   - clock
//        reset - synchronous active-high reset, clears the counter
//        tick  - high for one cycle every DIV cycles (every cycle when DIV = 1)
module prescaler_tick #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
    assign tick = r_cnt == LAST;
endmodule

// File: rtl/arranque_rampa_multinivel.sv
// arranque_rampa_multinivel: multilevel soft-start motor ramp with fast/slow dwell and emergency off
// Ports: i_clk      - clock
//        i_reset    - synchronous active-high reset (beats fault and run requests)
//        i_rapido   - run request, fast ramp (wins over i_lento)
//        i_lento    - run request, slow ramp
//        i_fault    - level-sensitive emergency off
//        o_level    - current speed level, 0 = off, N_LEVELS = full
//        o_out_lvl  - one-hot of o_level (bit i <=> level i+1), zero when off
//        o_busy     - ramping up or down
//        o_at_speed - holding full speed
module arranque_rampa_multinivel
    import arranque_pkg::*;
#(
    parameter int N_LEVELS   = 3,
    parameter int TICK_DIV   = 100000,
    parameter int FAST_DWELL = 2,
    parameter int SLOW_DWELL = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_rapido,
    input  logic                          i_lento,
    input  logic                          i_fault,
    output logic [lvl_w(N_LEVELS)-1:0]    o_level,
    output logic [N_LEVELS-1:0]           o_out_lvl,
    output logic                          o_busy,
    output logic                          o_at_speed
);
    localparam int LVL_W = lvl_w(N_LEVELS);
    localparam int MAXD = FAST_DWELL > SLOW_DWELL ? FAST_DWELL : SLOW_DWELL;
    localparam int DW_W = $clog2(MAXD + 1);
    localparam logic [LVL_W-1:0] L_PRE = LVL_W'(N_LEVELS - 1);
    localparam logic [LVL_W-1:0] L_MAX = LVL_W'(N_LEVELS);
    localparam logic [DW_W-1:0] FAST_LAST = DW_W'(FAST_DWELL - 1);
    localparam logic [DW_W-1:0] SLOW_LAST = DW_W'(SLOW_DWELL - 1);

    if (N_LEVELS < 2 || TICK_DIV < 1 || FAST_DWELL < 1 || SLOW_DWELL < 1) begin : g_bad_params
        $error("arranque_rampa_multinivel: illegal parameter values");
    end

    state_t           r_state, w_state_nx;
    mode_t            r_mode, w_mode_nx;
    logic [LVL_W-1:0] r_level, w_level_nx;
    logic [DW_W-1:0]  r_dwell, w_dwell_nx;
    logic             w_tick, w_req, w_last;

    prescaler_tick #(.DIV(TICK_DIV)) u_tick (
        .clk   (i_clk),
        .reset (i_reset),
        .tick  (w_tick)
    );

    assign w_req  = i_rapido | i_lento;
    // Dwell length comes from the latched mode, not the live inputs.
    assign w_last = r_dwell == (r_mode == FAST ? FAST_LAST : SLOW_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_level_nx = r_level;
        w_dwell_nx = r_dwell;
        if (i_fault) begin
            w_state_nx = IDLE;
            w_level_nx = '0;
            w_dwell_nx = '0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    w_state_nx = RAMP_UP;
                    w_mode_nx  = i_rapido ? FAST : SLOW;
                    w_level_nx = LVL_W'(1);
                    w_dwell_nx = '0;
                end
                RAMP_UP: if (!w_req) begin
                    w_state_nx = RAMP_DOWN;
                    w_dwell_nx = '0;
                end else if (r_level == L_MAX) begin
                    // Reversal caught right after RUN: already at full speed.
                    w_state_nx = RUN;
                end else if (w_tick) begin
                    w_dwell_nx = w_last ? '0 : r_dwell + 1'b1;
                    w_level_nx = w_last ? r_level + 1'b1 : r_level;
                    w_state_nx = (w_last && r_level == L_PRE) ? RUN : RAMP_UP;
                end
                RUN: if (!w_req) begin
                    w_state_nx = RAMP_DOWN;
                    w_dwell_nx = '0;
                end
                RAMP_DOWN: if (w_req) begin
                    w_state_nx = RAMP_UP;
                    w_mode_nx  = i_rapido ? FAST : SLOW;
                    w_dwell_nx = '0;
                end else if (w_tick) begin
                    w_dwell_nx = w_last ? '0 : r_dwell + 1'b1;
                    w_level_nx = w_last ? r_level - 1'b1 : r_level;
                    w_state_nx = (w_last && r_level == LVL_W'(1)) ? IDLE : RAMP_DOWN;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_mode  <= SLOW;
            r_level <= '0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_level <= w_level_nx;
            r_dwell <= w_dwell_nx;
        end
    end

    assign o_level    = r_level;
    assign o_busy     = r_state == RAMP_UP || r_state == RAMP_DOWN;
    assign o_at_speed = r_state == RUN;
    for (genvar i = 0; i < N_LEVELS; i++) begin : g_onehot
        assign o_out_lvl[i] = r_level == LVL_W'(i + 1);
    end
endmodule

// File: tb/tb_arranque_rampa_multinivel.sv
// tb_arranque_rampa_multinivel: scoreboard bench for the multilevel ramp starter
module tb_arranque_rampa_multinivel;
    localparam int I = 0, U = 1, R = 2, D = 3;

    typedef struct {
        string      nm;
        logic [1:0] lvl;
        logic [2:0] oh;
        logic       busy;
        logic       at;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, rapido, lento, fault;
    logic [1:0] o_level;
    logic [2:0] o_out_lvl;
    logic       o_busy, o_at_speed;
    exp_t       q[$];
    int         checks = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    arranque_rampa_multinivel #(
        .N_LEVELS   (3),
        .TICK_DIV   (1),
        .FAST_DWELL (2),
        .SLOW_DWELL (4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rapido   (rapido),
        .i_lento    (lento),
        .i_fault    (fault),
        .o_level    (o_level),
        .o_out_lvl  (o_out_lvl),
        .o_busy     (o_busy),
        .o_at_speed (o_at_speed)
    );

    // Drive inputs for the next edge and queue what that edge must produce.
    task automatic step(input logic rs, input logic ra, input logic le, input logic fl,
                        input int lvl, input int st, input string nm);
        exp_t e;
        reset  = rs;
        rapido = ra;
        lento  = le;
        fault  = fl;
        e.nm   = nm;
        e.lvl  = 2'(lvl);
        e.oh   = (lvl == 0) ? 3'b000 : 3'(1 << (lvl - 1));
        e.busy = (st == U) || (st == D);
        e.at   = (st == R);
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({o_level, o_out_lvl, o_busy, o_at_speed} !== {e.lvl, e.oh, e.busy, e.at}) begin
                    fails++;
                    $display("FAIL %s: got level=%0d out_lvl=%b busy=%b at_speed=%b, expected level=%0d out_lvl=%b busy=%b at_speed=%b",
                             e.nm, o_level, o_out_lvl, o_busy, o_at_speed, e.lvl, e.oh, e.busy, e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rapido = 1'b0; lento = 1'b0; fault = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, I, "reset");
        step(0, 1, 0, 0, 1, U, "fast e1");
        step(0, 1, 0, 0, 1, U, "fast e2");
        step(0, 1, 0, 0, 2, U, "fast e3");
        step(0, 1, 0, 0, 2, U, "fast e4");
        step(0, 1, 0, 0, 3, R, "fast e5");
        step(0, 1, 0, 0, 3, R, "fast run hold");
        step(0, 0, 0, 0, 3, D, "down e1");
        step(0, 0, 0, 0, 3, D, "down e2");
        step(0, 0, 0, 0, 2, D, "down e3");
        step(0, 0, 0, 0, 2, D, "down e4");
        step(0, 0, 0, 0, 1, D, "down e5");
        step(0, 0, 0, 0, 1, D, "down e6");
        step(0, 0, 0, 0, 0, I, "down idle");
        step(0, 0, 0, 0, 0, I, "idle stays");
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 1, U, "slow lvl1");
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 2, U, "slow lvl2");
        step(0, 0, 1, 0, 3, R, "slow run");
        step(0, 1, 1, 0, 3, R, "run both");
        step(0, 1, 0, 0, 3, R, "run mode change");
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 3, D, "slow down lvl3");
        step(0, 0, 0, 0, 2, D, "slow down lvl2");
        step(0, 1, 0, 0, 2, U, "reversal e1");
        step(0, 1, 0, 0, 2, U, "reversal e2");
        step(0, 1, 0, 0, 3, R, "reversal run");
        step(0, 0, 0, 0, 3, D, "pre fault e1");
        step(0, 0, 0, 0, 3, D, "pre fault e2");
        step(0, 0, 0, 0, 2, D, "pre fault e3");
        step(0, 1, 0, 1, 0, I, "fault");
        step(0, 1, 1, 1, 0, I, "fault held");
        step(0, 1, 1, 0, 1, U, "both e1");
        step(0, 1, 1, 0, 1, U, "both e2");
        step(0, 1, 1, 0, 2, U, "both e3");
        step(0, 1, 1, 0, 2, U, "both e4");
        step(0, 1, 1, 0, 3, R, "both e5");
        step(1, 1, 1, 1, 0, I, "reset priority");
        step(0, 0, 1, 0, 1, U, "slow after reset");
        step(0, 0, 0, 0, 1, D, "abort up");
        step(0, 0, 0, 0, 1, D, "abort d1");
        step(0, 0, 0, 0, 1, D, "abort d2");
        step(0, 0, 0, 0, 1, D, "abort d3");
        step(0, 0, 0, 0, 0, I, "abort idle");
        step(0, 1, 0, 0, 1, U, "restart e1");
        step(0, 1, 0, 0, 1, U, "restart e2");
        step(1, 1, 0, 0, 0, I, "reset mid ramp");
        step(0, 0, 0, 0, 0, I, "idle after reset");
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
